prog_counter: RTL and testbench

//   Parametrised up/down counter; next generation of the counter_if-driven counter.

---
 rtl/prog_counter_if.sv | 26 ++
 rtl/prog_counter.sv | 92 +++++++++
 tb/tb_prog_counter.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_counter_if.sv
// Control and status bundle for prog_counter: the stimulus side drives the
// master modport and the counter sits on the slave modport.
interface prog_counter_if #(
   parameter int WIDTH = 8
);
   logic             en;
   logic             up;
   logic             clr;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             oneshot;
   logic [WIDTH-1:0] count;
   logic             tc;
   logic             ovf;
   logic             done;

   modport master (
      output en, up, clr, load, load_val, oneshot,
      input  count, tc, ovf, done
   );

   modport slave (
      input  en, up, clr, load, load_val, oneshot,
      output count, tc, ovf, done
   );
endinterface

// File: rtl/prog_counter.sv
// Parametrised up/down counter with wrap or saturate at 0..MAX_VAL, sync
// clear/load, one-shot stop (DONE state), terminal-count pulse and sticky overflow.
module prog_counter #(
   parameter int             WIDTH    = 8,
   parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}},
   parameter bit             SATURATE = 1'b0
) (
   input  logic          clk,
   input  logic          rst,
   prog_counter_if.slave bus
);

   typedef enum logic {
      ST_COUNT = 1'b0,
      ST_DONE  = 1'b1
   } state_t;

   localparam logic [WIDTH-1:0] LP_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t           r_state;
   state_t           w_nextState;
   logic [WIDTH-1:0] r_count;
   logic [WIDTH-1:0] w_nextCount;
   logic [WIDTH-1:0] w_loadVal;
   logic             r_tc;
   logic             r_ovf;
   logic             w_nextTc;
   logic             w_nextOvf;
   logic             w_step;
   logic             w_boundary;

   // Loads above the terminal value are clamped so count never leaves 0..MAX_VAL.
   assign w_loadVal  = (bus.load_val > MAX_VAL) ? MAX_VAL : bus.load_val;
   assign w_step     = bus.en && (r_state == ST_COUNT);
   assign w_boundary = w_step && (bus.up ? (r_count == MAX_VAL) : (r_count == '0));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_COUNT;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      if (bus.clr || bus.load) begin
         w_nextState = ST_COUNT;
      end else if (w_boundary && bus.oneshot) begin
         w_nextState = ST_DONE;
      end
   end

   // A one-shot boundary event freezes count at the boundary regardless of wrap mode.
   always_comb begin
      w_nextCount = r_count;
      w_nextTc    = 1'b0;
      w_nextOvf   = r_ovf;
      if (bus.clr) begin
         w_nextCount = '0;
         w_nextOvf   = 1'b0;
      end else if (bus.load) begin
         w_nextCount = w_loadVal;
      end else if (w_boundary) begin
         w_nextTc  = 1'b1;
         w_nextOvf = 1'b1;
         if (!bus.oneshot && !SATURATE) begin
            w_nextCount = bus.up ? '0 : MAX_VAL;
         end
      end else if (w_step) begin
         w_nextCount = bus.up ? (r_count + LP_ONE) : (r_count - LP_ONE);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count <= '0;
         r_tc    <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_count <= w_nextCount;
         r_tc    <= w_nextTc;
         r_ovf   <= w_nextOvf;
      end
   end

   assign bus.count = r_count;
   assign bus.tc    = r_tc;
   assign bus.ovf   = r_ovf;
   assign bus.done  = (r_state == ST_DONE);

endmodule

// File: tb/tb_prog_counter.sv
// Self-checking bench: a wrapping and a saturating prog_counter (WIDTH=4, MAX_VAL=9)
// share one stimulus stream; table vectors, corner sequences and random cycles vs a model.
module tb_prog_counter;

   localparam int MAXV = 9;

   typedef struct {
      bit clr;
      bit load;
      bit en;
      bit up;
      bit oneshot;
      int loadVal;
      int expCount;
      bit expTc;
      bit expOvf;
      bit expDone;
   } vec_t;

   logic       clk;
   logic       rst;
   logic       dEn;
   logic       dUp;
   logic       dClr;
   logic       dLoad;
   logic       dOneshot;
   logic [3:0] dLoadVal;

   int nVectors;
   int nMiscompares;

   int mCount[2];
   bit mTc[2];
   bit mOvf[2];
   bit mDone[2];

   vec_t vecs[$];

   prog_counter_if #(.WIDTH(4)) wrapIf ();
   prog_counter_if #(.WIDTH(4)) satIf ();

   assign wrapIf.en       = dEn;
   assign wrapIf.up       = dUp;
   assign wrapIf.clr      = dClr;
   assign wrapIf.load     = dLoad;
   assign wrapIf.load_val = dLoadVal;
   assign wrapIf.oneshot  = dOneshot;
   assign satIf.en        = dEn;
   assign satIf.up        = dUp;
   assign satIf.clr       = dClr;
   assign satIf.load      = dLoad;
   assign satIf.load_val  = dLoadVal;
   assign satIf.oneshot   = dOneshot;

   prog_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b0)) uWrap (
      .clk (clk),
      .rst (rst),
      .bus (wrapIf)
   );

   prog_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b1)) uSat (
      .clk (clk),
      .rst (rst),
      .bus (satIf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(bit c, bit l, bit e, bit u, bit o, int lv,
                               int ec, bit etc, bit eo, bit ed);
      vec_t v;
      v.clr = c; v.load = l; v.en = e; v.up = u; v.oneshot = o; v.loadVal = lv;
      v.expCount = ec; v.expTc = etc; v.expOvf = eo; v.expDone = ed;
      return v;
   endfunction

   task automatic setInputs(bit c, bit l, bit e, bit u, bit o, int lv);
      dClr = c; dLoad = l; dEn = e; dUp = u; dOneshot = o; dLoadVal = lv[3:0];
   endtask

   // Drive one cycle's inputs and let the next rising edge take them.
   task automatic applyStimulus(bit c, bit l, bit e, bit u, bit o, int lv);
      setInputs(c, l, e, u, o, lv);
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
      nVectors++;
      if (actual !== expected) begin
         nMiscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic checkDut(string tag, int k, int ec, bit etc, bit eo, bit ed);
      if (k == 0) begin
         checkOutput({tag, ".wrap.count"}, 32'(wrapIf.count), ec);
         checkOutput({tag, ".wrap.tc"},    32'(wrapIf.tc),    32'(etc));
         checkOutput({tag, ".wrap.ovf"},   32'(wrapIf.ovf),   32'(eo));
         checkOutput({tag, ".wrap.done"},  32'(wrapIf.done),  32'(ed));
      end else begin
         checkOutput({tag, ".sat.count"}, 32'(satIf.count), ec);
         checkOutput({tag, ".sat.tc"},    32'(satIf.tc),    32'(etc));
         checkOutput({tag, ".sat.ovf"},   32'(satIf.ovf),   32'(eo));
         checkOutput({tag, ".sat.done"},  32'(satIf.done),  32'(ed));
      end
   endtask

   // Reference: take the intended step as plain integer arithmetic; landing outside
   // 0..MAXV is a boundary event, resolved by mode (wrap, saturate or one-shot stop).
   task automatic modelStep(int k);
      int target;
      if (dClr) begin
         mCount[k] = 0; mTc[k] = 0; mOvf[k] = 0; mDone[k] = 0;
      end else if (dLoad) begin
         mCount[k] = (int'(dLoadVal) > MAXV) ? MAXV : int'(dLoadVal);
         mTc[k] = 0; mDone[k] = 0;
      end else if (dEn && !mDone[k]) begin
         target = dUp ? mCount[k] + 1 : mCount[k] - 1;
         if (target > MAXV || target < 0) begin
            mTc[k] = 1; mOvf[k] = 1;
            if (dOneshot) mDone[k] = 1;
            else if (k == 0) mCount[k] = (target > MAXV) ? 0 : MAXV;
         end else begin
            mCount[k] = target; mTc[k] = 0;
         end
      end else begin
         mTc[k] = 0;
      end
   endtask

   initial begin
      nVectors = 0;
      nMiscompares = 0;
      rst = 1'b0;
      setInputs(0, 0, 1, 1, 0, 0);

      // Reset holds everything at zero even with en high across clock edges.
      repeat (2) @(posedge clk);
      #1;
      checkDut("reset", 0, 0, 0, 0, 0);
      checkDut("reset", 1, 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b1;

      // Wrapping-counter vectors: up-count wrap, down-count wrap, one-shot, load rules.
      for (int i = 1; i <= 9; i++) vecs.push_back(mk(0,0,1,1,0,0, i,0,0,0));
      vecs.push_back(mk(0,0,1,1,0,0,  0,1,1,0));
      vecs.push_back(mk(0,0,1,1,0,0,  1,0,1,0));
      vecs.push_back(mk(0,0,1,1,0,0,  2,0,1,0));
      vecs.push_back(mk(0,1,0,0,0,2,  2,0,1,0));
      vecs.push_back(mk(0,0,1,0,0,0,  1,0,1,0));
      vecs.push_back(mk(0,0,1,0,0,0,  0,0,1,0));
      vecs.push_back(mk(0,0,1,0,0,0,  9,1,1,0));
      vecs.push_back(mk(0,0,1,0,0,0,  8,0,1,0));
      vecs.push_back(mk(1,0,0,0,0,0,  0,0,0,0));
      vecs.push_back(mk(0,1,0,0,1,7,  7,0,0,0));
      vecs.push_back(mk(0,0,1,1,1,0,  8,0,0,0));
      vecs.push_back(mk(0,0,1,1,1,0,  9,0,0,0));
      vecs.push_back(mk(0,0,1,1,1,0,  9,1,1,1));
      vecs.push_back(mk(0,0,1,1,1,0,  9,0,1,1));
      vecs.push_back(mk(0,0,1,0,1,0,  9,0,1,1));
      vecs.push_back(mk(0,1,0,0,1,3,  3,0,1,0));
      vecs.push_back(mk(0,0,1,1,0,0,  4,0,1,0));
      vecs.push_back(mk(0,1,0,0,0,15, 9,0,1,0));
      vecs.push_back(mk(1,1,0,0,0,5,  0,0,0,0));
      vecs.push_back(mk(0,1,1,1,0,6,  6,0,0,0));
      vecs.push_back(mk(0,1,1,0,0,0,  0,0,0,0));
      vecs.push_back(mk(0,1,0,0,0,9,  9,0,0,0));
      vecs.push_back(mk(0,0,1,1,1,0,  9,1,1,1));
      vecs.push_back(mk(1,0,1,1,1,0,  0,0,0,0));
      vecs.push_back(mk(0,0,1,1,0,0,  1,0,0,0));
      vecs.push_back(mk(0,0,0,1,0,0,  1,0,0,0));

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].clr, vecs[i].load, vecs[i].en, vecs[i].up,
                       vecs[i].oneshot, vecs[i].loadVal);
         checkDut($sformatf("vec%0d", i), 0, vecs[i].expCount, vecs[i].expTc,
                  vecs[i].expOvf, vecs[i].expDone);
      end

      // Saturating mode holds at MAX_VAL with tc on every boundary cycle; clr drops ovf.
      applyStimulus(1, 0, 0, 0, 0, 0);
      checkDut("sat.clr0", 1, 0, 0, 0, 0);
      applyStimulus(0, 1, 0, 0, 0, 8);
      checkDut("sat.load8", 1, 8, 0, 0, 0);
      applyStimulus(0, 0, 1, 1, 0, 0);
      checkDut("sat.up1", 1, 9, 0, 0, 0);
      checkDut("sat.up1", 0, 9, 0, 0, 0);
      applyStimulus(0, 0, 1, 1, 0, 0);
      checkDut("sat.up2", 1, 9, 1, 1, 0);
      checkDut("sat.up2", 0, 0, 1, 1, 0);
      applyStimulus(0, 0, 1, 1, 0, 0);
      checkDut("sat.up3", 1, 9, 1, 1, 0);
      checkDut("sat.up3", 0, 1, 0, 1, 0);
      applyStimulus(1, 0, 0, 0, 0, 0);
      checkDut("sat.clr1", 1, 0, 0, 0, 0);
      applyStimulus(0, 0, 1, 0, 0, 0);
      checkDut("sat.down0", 1, 0, 1, 1, 0);
      checkDut("sat.down0", 0, 9, 1, 1, 0);

      // Asynchronous reset between edges, taken while both counters sit in DONE with tc high.
      applyStimulus(0, 1, 0, 0, 1, 9);
      applyStimulus(0, 0, 1, 1, 1, 0);
      checkDut("pre_rst", 0, 9, 1, 1, 1);
      checkDut("pre_rst", 1, 9, 1, 1, 1);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkDut("async_rst", 0, 0, 0, 0, 0);
      checkDut("async_rst", 1, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      checkDut("rst_held", 0, 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b1;
      applyStimulus(0, 0, 1, 1, 0, 0);
      checkDut("post_rst", 0, 1, 0, 0, 0);
      checkDut("post_rst", 1, 1, 0, 0, 0);

      // Random cycles against the model, starting from a known cleared state.
      applyStimulus(1, 0, 0, 0, 0, 0);
      for (int k = 0; k < 2; k++) begin
         mCount[k] = 0; mTc[k] = 0; mOvf[k] = 0; mDone[k] = 0;
      end
      for (int n = 0; n < 600; n++) begin
         setInputs(($urandom_range(15) == 0), ($urandom_range(9) == 0),
                   ($urandom_range(3) != 0), $urandom_range(1),
                   ($urandom_range(3) == 0), $urandom_range(15));
         modelStep(0);
         modelStep(1);
         @(posedge clk);
         #1;
         checkDut($sformatf("rnd%0d", n), 0, mCount[0], mTc[0], mOvf[0], mDone[0]);
         checkDut($sformatf("rnd%0d", n), 1, mCount[1], mTc[1], mOvf[1], mDone[1]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end

endmodule
